// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the five-stage core: RV32 opcode constants, the
// hazard controller FSM state encoding, and register-usage decode helpers.
// Latency: n/a (types and pure functions). Backpressure: n/a.
package hazard_ctrl_pkg;

  // Major opcodes, also used by the decode and immediate-generation logic.
  localparam logic [6:0] R_TYPE      = 7'b0110011;
  localparam logic [6:0] I_TYPE      = 7'b0010011;
  localparam logic [6:0] LOAD_TYPE   = 7'b0000011;
  localparam logic [6:0] STORE_TYPE  = 7'b0100011;
  localparam logic [6:0] BRANCH_TYPE = 7'b1100011;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_e;

  // Opcodes whose rs1 field names a real source register.
  function automatic logic uses_rs1(input logic [6:0] op);
    return (op == R_TYPE) || (op == STORE_TYPE) || (op == BRANCH_TYPE) ||
           (op == I_TYPE) || (op == LOAD_TYPE);
  endfunction

  // Opcodes whose rs2 field names a real source register.
  function automatic logic uses_rs2(input logic [6:0] op);
    return (op == R_TYPE) || (op == STORE_TYPE) || (op == BRANCH_TYPE);
  endfunction

endpackage

// File: rtl/hazard_ctrl_perf.sv
// Saturating stall/flush event counter pair for pipeline performance monitoring.
// Latency: count visible one cycle after the event. Backpressure: none, counters hold at all-ones.
// Ports: clk_i, rst_i (sync active-low), stall_inc_i/flush_inc_i events, stall_cnt_o/flush_cnt_o.
module hazard_ctrl_perf #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             stall_inc_i,
  input  logic             flush_inc_i,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_inc_i && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (flush_inc_i && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use / branch-operand bubbles, ID-branch flush, dmem wait freeze + watchdog.
// Latency: all hazard outputs combinational (zero cycles) from inputs and registered FSM state.
// Backpressure: dmem not acking freezes the pipe; a hung memory latches err_o until reset.
// Ports: clk_i, rst_i (sync active-low); IF/ID inst, ID/EX rd/memread/regwrite, branch_taken_i,
// dmem_req_i/dmem_ack_i in; pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, pipe_stall_o, err_o out.
// Optional: define HAZARD_CTRL_PERF_EN to add CNT_W-wide stall_cnt_o/flush_cnt_o saturating counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
`ifdef HAZARD_CTRL_PERF_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] id_inst_i,
  input  logic [4:0]  ex_rd_i,
  input  logic        ex_memread_i,
  input  logic        ex_regwrite_i,
  input  logic        branch_taken_i,
  input  logic        dmem_req_i,
  input  logic        dmem_ack_i,
  output logic        pc_write_o,
  output logic        ifid_write_o,
  output logic        ifid_flush_o,
  output logic        idex_bubble_o,
  output logic        pipe_stall_o,
  output logic        err_o
`ifdef HAZARD_CTRL_PERF_EN
  , output logic [CNT_W-1:0] stall_cnt_o
  , output logic [CNT_W-1:0] flush_cnt_o
`endif
);

  // wait_cnt only needs to reach MEM_TIMEOUT-2: the transition to ERR is taken
  // from that value, i.e. when the count would become MEM_TIMEOUT-1.
  localparam int          CW        = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(MEM_TIMEOUT - 2);

  state_e        state_q, state_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;

  logic [6:0] opcode;
  logic [4:0] rs1, rs2;
  logic       rs_hit, load_use, br_dep, mem_stall;
  logic       unused_inst_bits;

  assign opcode           = id_inst_i[6:0];
  assign rs1              = id_inst_i[19:15];
  assign rs2              = id_inst_i[24:20];
  assign unused_inst_bits = ^{id_inst_i[31:25], id_inst_i[14:7]};

  always_comb begin
    // x0 is hardwired zero, so writing it never creates a dependency.
    rs_hit = (ex_rd_i != 5'd0) &&
             ((uses_rs1(opcode) && (rs1 == ex_rd_i)) ||
              (uses_rs2(opcode) && (rs2 == ex_rd_i)));
    load_use = ex_memread_i && rs_hit;
    // ALU results are forwarded to EX but not to the ID comparator; loads are
    // already covered by load_use.
    br_dep = (opcode == BRANCH_TYPE) && ex_regwrite_i && !ex_memread_i && rs_hit;
    mem_stall = ((state_q == RUN) && dmem_req_i && !dmem_ack_i) ||
                ((state_q == MEM_WAIT) && !dmem_ack_i);
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      RUN: begin
        if (dmem_req_i && !dmem_ack_i) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = '0;
        end
      end
      MEM_WAIT: begin
        if (dmem_ack_i)                    state_d    = RUN;
        else if (wait_cnt_q == WAIT_LAST)  state_d    = ERR;
        else                               wait_cnt_d = wait_cnt_q + CW'(1);
      end
      ERR:     state_d = ERR;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    pc_write_o    = 1'b1;
    ifid_write_o  = 1'b1;
    ifid_flush_o  = 1'b0;
    idex_bubble_o = 1'b0;
    pipe_stall_o  = 1'b0;
    err_o         = 1'b0;
    if (!rst_i) begin
      // Hold everything frozen while reset is applied.
      pc_write_o   = 1'b0;
      ifid_write_o = 1'b0;
      pipe_stall_o = 1'b1;
    end else if ((state_q == ERR) || mem_stall) begin
      pc_write_o   = 1'b0;
      ifid_write_o = 1'b0;
      pipe_stall_o = 1'b1;
      err_o        = (state_q == ERR);
    end else if (load_use || br_dep) begin
      // A taken branch here used stale operands, so it is not acted on.
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      idex_bubble_o = 1'b1;
    end else if (branch_taken_i) begin
      ifid_flush_o = 1'b1;
    end
  end

`ifdef HAZARD_CTRL_PERF_EN
  hazard_ctrl_perf #(
    .CNT_W(CNT_W)
  ) u_perf (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .stall_inc_i (!pc_write_o),
    .flush_inc_i (ifid_flush_o),
    .stall_cnt_o (stall_cnt_o),
    .flush_cnt_o (flush_cnt_o)
  );
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl with MEM_TIMEOUT=4.
// Expected output vector order: {pc_write, ifid_write, flush, bubble, stall, err}.
module tb_hazard_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] id_inst_i;
  logic [4:0]  ex_rd_i;
  logic        ex_memread_i, ex_regwrite_i, branch_taken_i, dmem_req_i, dmem_ack_i;
  logic        pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, pipe_stall_o, err_o;
`ifdef HAZARD_CTRL_PERF_EN
  logic [31:0] stall_cnt_o, flush_cnt_o;
`endif

  always #5 clk_i = ~clk_i;

  hazard_ctrl #(
    .MEM_TIMEOUT(4)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .id_inst_i      (id_inst_i),
    .ex_rd_i        (ex_rd_i),
    .ex_memread_i   (ex_memread_i),
    .ex_regwrite_i  (ex_regwrite_i),
    .branch_taken_i (branch_taken_i),
    .dmem_req_i     (dmem_req_i),
    .dmem_ack_i     (dmem_ack_i),
    .pc_write_o     (pc_write_o),
    .ifid_write_o   (ifid_write_o),
    .ifid_flush_o   (ifid_flush_o),
    .idex_bubble_o  (idex_bubble_o),
    .pipe_stall_o   (pipe_stall_o),
    .err_o          (err_o)
`ifdef HAZARD_CTRL_PERF_EN
    , .stall_cnt_o  (stall_cnt_o)
    , .flush_cnt_o  (flush_cnt_o)
`endif
  );

  localparam logic [5:0] NORM  = 6'b110000;
  localparam logic [5:0] BUBL  = 6'b000100;
  localparam logic [5:0] FLSH  = 6'b111000;
  localparam logic [5:0] STAL  = 6'b000010;
  localparam logic [5:0] ERRV  = 6'b000011;
  localparam logic [5:0] RSTV  = 6'b000010;

  int checks   = 0;
  int failures = 0;

  logic [5:0] exp_q[$];
  string      name_q[$];

  typedef struct {
    string       name;
    logic [31:0] inst;
    logic [4:0]  rd;
    logic        mr, rw, tk;
    logic [5:0]  exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] r_inst(input logic [4:0] rd, rs1, rs2);
    return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] i_inst(input logic [4:0] rd, rs1, input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, 7'b0010011};
  endfunction
  function automatic logic [31:0] s_inst(input logic [4:0] rs2, rs1);
    return {7'b0, rs2, rs1, 3'b010, 5'b0, 7'b0100011};
  endfunction
  function automatic logic [31:0] b_inst(input logic [4:0] rs1, rs2);
    return {7'b0, rs2, rs1, 3'b000, 5'b0, 7'b1100011};
  endfunction

  task automatic check_out();
    logic [5:0] act, exp;
    string      nm;
    act = {pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, pipe_stall_o, err_o};
    exp = exp_q.pop_front();
    nm  = name_q.pop_front();
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got pc/ifid/flush/bubble/stall/err=%b expected %b", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs, queue its expectation, compare mid-cycle.
  task automatic step(input logic [31:0] inst, input logic [4:0] rd,
                      input logic mr, rw, tk, rq, ak, rs,
                      input logic [5:0] exp, input string nm);
    id_inst_i      = inst;
    ex_rd_i        = rd;
    ex_memread_i   = mr;
    ex_regwrite_i  = rw;
    branch_taken_i = tk;
    dmem_req_i     = rq;
    dmem_ack_i     = ak;
    rst_i          = rs;
    exp_q.push_back(exp);
    name_q.push_back(nm);
    @(negedge clk_i);
    check_out();
    @(posedge clk_i);
    #1;
  endtask

  logic [31:0] add_dep, nop_i;

  initial begin
    add_dep = r_inst(5'd6, 5'd5, 5'd1);
    nop_i   = i_inst(5'd0, 5'd0, 12'd0);

    vecs.push_back('{"lu_rs1",      add_dep,                     5'd5, 1, 1, 0, BUBL});
    vecs.push_back('{"lu_rs2",      r_inst(5'd6, 5'd1, 5'd5),    5'd5, 1, 1, 0, BUBL});
    vecs.push_back('{"lu_addi_x0",  i_inst(5'd6, 5'd0, 12'd3),   5'd5, 1, 1, 0, NORM});
    vecs.push_back('{"lu_rd0",      r_inst(5'd6, 5'd0, 5'd1),    5'd0, 1, 1, 0, NORM});
    vecs.push_back('{"itype_no_rs2",i_inst(5'd6, 5'd1, 12'd5),   5'd5, 1, 1, 0, NORM});
    vecs.push_back('{"store_rs2",   s_inst(5'd5, 5'd1),          5'd5, 1, 1, 0, BUBL});
    vecs.push_back('{"lui_no_rs",   {12'd0, 5'd5, 3'b0, 5'd6, 7'b0110111}, 5'd5, 1, 1, 0, NORM});
    vecs.push_back('{"br_dep",      b_inst(5'd7, 5'd2),          5'd7, 0, 1, 1, BUBL});
    vecs.push_back('{"br_no_rw",    b_inst(5'd7, 5'd2),          5'd7, 0, 0, 1, FLSH});
    vecs.push_back('{"br_load_dep", b_inst(5'd7, 5'd2),          5'd7, 1, 1, 1, BUBL});
    vecs.push_back('{"alu_dep_nobr",r_inst(5'd6, 5'd7, 5'd2),    5'd7, 0, 1, 0, NORM});
    vecs.push_back('{"br_nodep",    b_inst(5'd1, 5'd2),          5'd7, 0, 1, 0, NORM});
    vecs.push_back('{"taken_flush", nop_i,                       5'd0, 0, 0, 1, FLSH});

    id_inst_i = nop_i; ex_rd_i = '0; ex_memread_i = 0; ex_regwrite_i = 0;
    branch_taken_i = 0; dmem_req_i = 0; dmem_ack_i = 0; rst_i = 0;
    @(posedge clk_i); #1;

    // Reset state, including a pending request being ignored.
    step(nop_i, 5'd0, 0, 0, 0, 0, 0, 0, RSTV, "reset_idle");
    step(add_dep, 5'd5, 1, 1, 1, 1, 0, 0, RSTV, "reset_busy");

    foreach (vecs[i])
      step(vecs[i].inst, vecs[i].rd, vecs[i].mr, vecs[i].rw, vecs[i].tk, 0, 0, 1,
           vecs[i].exp, vecs[i].name);

    // Load-use bubble lasts one cycle once the load leaves EX.
    step(add_dep, 5'd5, 1, 1, 0, 0, 0, 1, BUBL, "lu_seq_c0");
    step(add_dep, 5'd0, 0, 0, 0, 0, 0, 1, NORM, "lu_seq_c1");

    // Branch dependency, then the branch resolves and flushes.
    step(b_inst(5'd7, 5'd2), 5'd7, 0, 1, 1, 0, 0, 1, BUBL, "br_seq_c0");
    step(b_inst(5'd7, 5'd2), 5'd0, 0, 0, 1, 0, 0, 1, FLSH, "br_seq_c1");

    // Ack after 3 cycles: exactly 3 stall cycles, load-use masked by stall.
    step(nop_i,   5'd0, 0, 0, 0, 1, 0, 1, STAL, "mem3_c0");
    step(add_dep, 5'd5, 1, 1, 1, 1, 0, 1, STAL, "mem3_c1_lu");
    step(nop_i,   5'd0, 0, 0, 0, 1, 0, 1, STAL, "mem3_c2");
    step(nop_i,   5'd0, 0, 0, 0, 1, 1, 1, NORM, "mem3_ack");
    step(nop_i,   5'd0, 0, 0, 0, 0, 0, 1, NORM, "mem3_after");

    // Same-cycle ack: no stall. Next-cycle ack: one stall.
    step(nop_i, 5'd0, 0, 0, 0, 1, 1, 1, NORM, "mem0_ack");
    step(nop_i, 5'd0, 0, 0, 0, 1, 0, 1, STAL, "mem1_c0");
    step(nop_i, 5'd0, 0, 0, 0, 1, 1, 1, NORM, "mem1_ack");

    // Watchdog: 4 stall cycles, then ERR; late ack ignored; reset clears.
    for (int c = 0; c < 4; c++)
      step(nop_i, 5'd0, 0, 0, 0, 1, 0, 1, STAL, $sformatf("tmo_stall%0d", c));
    step(nop_i, 5'd0, 0, 0, 0, 1, 0, 1, ERRV, "tmo_err");
    step(nop_i, 5'd0, 0, 0, 1, 1, 1, 1, ERRV, "tmo_late_ack");
    step(nop_i, 5'd0, 0, 0, 0, 0, 0, 1, ERRV, "tmo_sticky");
    step(nop_i, 5'd0, 0, 0, 0, 0, 0, 0, RSTV, "tmo_rst");
    step(nop_i, 5'd0, 0, 0, 0, 0, 0, 1, NORM, "tmo_run");

    // Reset mid-MEM_WAIT returns to RUN.
    step(nop_i, 5'd0, 0, 0, 0, 1, 0, 1, STAL, "mw_rst_c0");
    step(nop_i, 5'd0, 0, 0, 0, 1, 0, 1, STAL, "mw_rst_c1");
    step(nop_i, 5'd0, 0, 0, 0, 1, 0, 0, RSTV, "mw_rst_rst");
    step(nop_i, 5'd0, 0, 0, 0, 0, 0, 1, NORM, "mw_rst_run");

`ifdef HAZARD_CTRL_PERF_EN
    step(nop_i,   5'd0, 0, 0, 0, 0, 0, 0, RSTV, "perf_rst");
    step(add_dep, 5'd5, 1, 1, 0, 0, 0, 1, BUBL, "perf_lu0");
    step(nop_i,   5'd0, 0, 0, 0, 0, 0, 1, NORM, "perf_n0");
    step(add_dep, 5'd5, 1, 1, 0, 0, 0, 1, BUBL, "perf_lu1");
    step(nop_i,   5'd0, 0, 0, 0, 1, 0, 1, STAL, "perf_m0");
    step(nop_i,   5'd0, 0, 0, 0, 1, 0, 1, STAL, "perf_m1");
    step(nop_i,   5'd0, 0, 0, 0, 1, 0, 1, STAL, "perf_m2");
    step(nop_i,   5'd0, 0, 0, 0, 1, 1, 1, NORM, "perf_ack");
    step(nop_i,   5'd0, 0, 0, 1, 0, 0, 1, FLSH, "perf_flush");
    checks++;
    if (stall_cnt_o !== 32'd5) begin
      failures++;
      $display("FAIL perf_stall_cnt: got %0d expected 5", stall_cnt_o);
    end
    checks++;
    if (flush_cnt_o !== 32'd1) begin
      failures++;
      $display("FAIL perf_flush_cnt: got %0d expected 1", flush_cnt_o);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
